// File: rtl/seg7_time_display.sv
// seg7_time_display: scans six BCD time digits onto a 4-digit multiplexed
// common-anode 7-segment display (hh:mm or mm:ss). Each frame works from a
// snapshot taken at frame start, so digits never tear mid-scan. Every slot
// opens with a dead-time blank, hours-tens leading zero is blanked, and the
// colon blinks.
module seg7_time_display #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int BLINK_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    input  logic [3:0] m1,
    input  logic [3:0] m2,
    input  logic [3:0] h1,
    input  logic [3:0] h2,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK  = CW'(BLANK_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    // IDLE: display disabled (or just out of reset); scan parked at slot 0.
    // SCAN: running; the first enabled edge out of IDLE is a frame start.
    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    typedef struct packed {
        logic       mode;
        logic [3:0] h2, h1, m2, m1, s2, s1;
    } snap_t;

    state_t        state, state_nx;
    logic [1:0]    idx, idx_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          take;
    snap_t         sh;
    logic [BW-1:0] bcnt;
    logic          phase;

    logic          lit;
    logic [3:0]    digit;
    logic [6:0]    seg_nx;
    logic [3:0]    an_nx;
    logic          dp_nx;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'h40;
            4'd1:    dec7 = 7'h79;
            4'd2:    dec7 = 7'h24;
            4'd3:    dec7 = 7'h30;
            4'd4:    dec7 = 7'h19;
            4'd5:    dec7 = 7'h12;
            4'd6:    dec7 = 7'h02;
            4'd7:    dec7 = 7'h78;
            4'd8:    dec7 = 7'h00;
            4'd9:    dec7 = 7'h10;
            default: dec7 = 7'h3F;  // non-BCD shows a dash
        endcase
    endfunction

    // Scan state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
        end
    end

    // Scan next-state; take flags an edge that (re)enters slot 0 at count 0.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        take     = 1'b0;
        case (state)
            ST_IDLE: begin
                // idx/cnt are already 0 here; stay at (0,0) and start a frame
                if (en) begin
                    state_nx = ST_SCAN;
                    take     = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!en) begin
                    state_nx = ST_IDLE;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                    idx_nx = idx + 2'd1;
                    take   = (idx == 2'd3);
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Frame snapshot: all decode works from these registers only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh <= '0;
        end else if (take) begin
            sh <= '{mode: mode, h2: h2, h1: h1, m2: m2, m1: m1, s2: s2, s1: s1};
        end
    end

    // Colon blink timebase, free-running independent of en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (bcnt == BLINK_LAST) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt  <= bcnt + 1'b1;
        end
    end

    // Digit select and decode for the current slot, outside the blank window.
    always_comb begin
        lit = (state == ST_SCAN) && en && (cnt >= CNT_BLANK);
        case ({sh.mode, idx})
            3'b0_11: digit = sh.h2;
            3'b0_10: digit = sh.h1;
            3'b0_01: digit = sh.m2;
            3'b0_00: digit = sh.m1;
            3'b1_11: digit = sh.m2;
            3'b1_10: digit = sh.m1;
            3'b1_01: digit = sh.s2;
            default: digit = sh.s1;
        endcase
        seg_nx = 7'h7F;
        an_nx  = 4'hF;
        dp_nx  = 1'b1;
        if (lit) begin
            an_nx  = ~(4'b0001 << idx);
            seg_nx = (!sh.mode && idx == 2'd3 && sh.h2 == 4'd0) ? 7'h7F : dec7(digit);
            dp_nx  = !(idx == 2'd2 && phase);
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an          <= 4'hF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nx;
            seg         <= seg_nx;
            dp          <= dp_nx;
            frame_start <= take;
        end
    end

endmodule

// File: tb/tb_seg7_time_display.sv
// Randomized bench for seg7_time_display against a frame-position reference
// model: the model tracks cycles since frame start and cycles since reset and
// derives slot, blank window, snapshot and colon phase arithmetically.
module tb_seg7_time_display;

    localparam int DC = 8;
    localparam int BL = 2;
    localparam int BC = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] s1 = 4'd0, s2 = 4'd0, m1 = 4'd0, m2 = 4'd0, h1 = 4'd0, h2 = 4'd0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_start;

    int errs = 0;
    int checks = 0;

    seg7_time_display #(
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BL),
        .BLINK_CYCLES(BC)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .s1(s1), .s2(s2), .m1(m1), .m2(m2), .h1(h1), .h2(h2),
        .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] seg_tbl [16];
    int         pos = -1;     // cycles since frame 0 start, -1 = not scanning
    int         cyc = 0;      // clock edges since reset release
    int         slot, w;
    logic       ph;
    logic [3:0] snap [4];
    logic       snap_mode = 1'b0;
    logic [3:0] e_an = 4'hF;
    logic [6:0] e_seg = 7'h7F;
    logic       e_dp = 1'b1;
    logic       e_fs = 1'b0;
    logic       e_segchk = 1'b1;

    initial begin
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        for (int i = 0; i < 4; i++) snap[i] = 4'd0;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos = -1; cyc = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_segchk = 1'b1;
        end else begin
            ph = ((cyc / BC) % 2) == 1;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_segchk = 1'b1;
            if (!en) begin
                pos = -1;
            end else begin
                if (pos >= 0) begin
                    slot = (pos / DC) % 4;
                    w    = pos % DC;
                    if (w >= BL) begin
                        e_an  = 4'hF & ~(4'b0001 << slot);
                        e_seg = (slot == 3 && !snap_mode && snap[3] == 4'd0) ? 7'h7F : seg_tbl[snap[slot]];
                        e_dp  = !(slot == 2 && ph);
                    end else begin
                        e_segchk = 1'b0;  // segment pattern is don't-care while dark
                    end
                    pos++;
                end else begin
                    pos = 0;
                end
                if (pos % (4 * DC) == 0) begin
                    e_fs = 1'b1;
                    snap_mode = mode;
                    if (!mode) begin snap[3] = h2; snap[2] = h1; snap[1] = m2; snap[0] = m1; end
                    else       begin snap[3] = m2; snap[2] = m1; snap[1] = s2; snap[0] = s1; end
                end
            end
            cyc++;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic cmp_all();
        check("an", {28'd0, an}, {28'd0, e_an});
        if (e_segchk) check("seg", {25'd0, seg}, {25'd0, e_seg});
        check("dp", {31'd0, dp}, {31'd0, e_dp});
        check("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
    endtask

    task automatic rand_digit(output logic [3:0] d, input int hi);
        if ($urandom_range(0, 7) == 0) d = 4'($urandom_range(10, 15));
        else                           d = 4'($urandom_range(0, hi));
    endtask

    task automatic stim();
        logic [3:0] d;
        if ($urandom_range(0, 29) == 0) begin
            case ($urandom_range(0, 5))
                0: begin rand_digit(d, 9); s1 = d; end
                1: begin rand_digit(d, 5); s2 = d; end
                2: begin rand_digit(d, 9); m1 = d; end
                3: begin rand_digit(d, 5); m2 = d; end
                4: begin rand_digit(d, 9); h1 = d; end
                default: h2 = 4'($urandom_range(0, 2));
            endcase
        end
        if ($urandom_range(0, 199) == 0) mode = ~mode;
        if (en) begin
            if ($urandom_range(0, 149) == 0) en = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            en = 1'b1;
        end
    endtask

    initial begin
        // reset held for a few edges, then released with en=1 and 12:34:56
        h2 = 4'd1; h1 = 4'd2; m2 = 4'd3; m1 = 4'd4; s2 = 4'd5; s1 = 4'd6;
        en = 1'b1;
        repeat (3) begin @(negedge clk); cmp_all(); end
        rst = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            cmp_all();
            if (c == 1500 || c == 2700) begin
                // asynchronous reset between clock edges
                #3 rst = 1'b0;
                #1;
                check("rst_an", {28'd0, an}, 32'hF);
                check("rst_seg", {25'd0, seg}, 32'h7F);
                check("rst_dp", {31'd0, dp}, 32'd1);
                check("rst_fs", {31'd0, frame_start}, 32'd0);
                repeat (2) begin @(negedge clk); cmp_all(); end
                en  = 1'b1;
                rst = 1'b1;
            end else if (c > 60) begin
                stim();
            end
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
